// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and constants for the pipeline hazard controller
package hazard_ctrl_pkg;
  localparam logic [1:0] RES_MEM = 2'b01;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_t;
  typedef enum logic {MIDLE, MWAIT} mem_state_t;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} halt_state_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-control bundle between the core datapath and the hazard controller
interface hazard_ctrl_if import hazard_ctrl_pkg::*; #(parameter int CNT_W = 32) ();
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] result_src_e;
  logic pc_src_e, reg_write_m, reg_write_w, mem_req_m, mem_ready, halt_req;
  logic stall_f, stall_d, flush_d, en_e, flush_e, en_m, flush_w, halted, mem_timeout;
  fwd_sel_t fwd_a_e, fwd_b_e;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, result_src_e, pc_src_e,
           reg_write_m, reg_write_w, mem_req_m, mem_ready, halt_req,
    input  stall_f, stall_d, flush_d, en_e, flush_e, en_m, flush_w, halted, mem_timeout,
           fwd_a_e, fwd_b_e, stall_cycles
  );
  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, result_src_e, pc_src_e,
           reg_write_m, reg_write_w, mem_req_m, mem_ready, halt_req,
    output stall_f, stall_d, flush_d, en_e, flush_e, en_m, flush_w, halted, mem_timeout,
           fwd_a_e, fwd_b_e, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// hazard_ctrl_fwd_sel: E-stage operand forwarding select, M result preferred over W, x0 never forwarded
module hazard_ctrl_fwd_sel import hazard_ctrl_pkg::*; (
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output fwd_sel_t   sel
);
  always_comb sel = (reg_write_m && rd_m != 5'd0 && rd_m == rs) ? FWD_M :
                    (reg_write_w && rd_w != 5'd0 && rd_w == rs) ? FWD_W : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the 5-stage RV32I pipeline with memory-wait and debug-halt FSMs
module hazard_ctrl import hazard_ctrl_pkg::*; #(
  parameter int PIPE_DRAIN  = 3,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave hif
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam int DW = $clog2(PIPE_DRAIN + 1);
  mem_state_t       ms;
  halt_state_t      hs;
  logic [WW-1:0]    wait_cnt;
  logic [DW-1:0]    drain_cnt;
  logic [CNT_W-1:0] sc;
  logic             mstall, lwstall, drain, hlt, halted_q, mto_q;
  hazard_ctrl_fwd_sel u_fwd_a (.rs(hif.rs1_e), .rd_m(hif.rd_m), .rd_w(hif.rd_w),
    .reg_write_m(hif.reg_write_m), .reg_write_w(hif.reg_write_w), .sel(hif.fwd_a_e));
  hazard_ctrl_fwd_sel u_fwd_b (.rs(hif.rs2_e), .rd_m(hif.rd_m), .rd_w(hif.rd_w),
    .reg_write_m(hif.reg_write_m), .reg_write_w(hif.reg_write_w), .sel(hif.fwd_b_e));
  // mstall freezes everything, so a branch held in E only flushes once memory completes
  always_comb begin
    mstall      = hif.mem_req_m & ~hif.mem_ready;
    lwstall     = hif.result_src_e == RES_MEM && hif.rd_e != 5'd0 &&
                  (hif.rd_e == hif.rs1_d || hif.rd_e == hif.rs2_d);
    drain       = hs == DRAIN;
    hlt         = hs == HALTED;
    hif.stall_f = mstall | (~hif.pc_src_e & (lwstall | drain | hlt));
    hif.stall_d = mstall | (~hif.pc_src_e & (lwstall | hlt));
    hif.flush_d = ~mstall & (hif.pc_src_e | (drain & ~lwstall));
    hif.flush_e = ~mstall & (hif.pc_src_e | lwstall);
    hif.en_e    = ~(mstall | hlt);
    hif.en_m    = ~(mstall | hlt);
    hif.flush_w = mstall;
  end
  assign hif.halted       = halted_q;
  assign hif.mem_timeout  = mto_q;
  assign hif.stall_cycles = sc;
  // wait_cnt counts wait cycles including the first one seen in MIDLE, saturating at MEM_TIMEOUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms        <= MIDLE;
      hs        <= RUN;
      wait_cnt  <= '0;
      drain_cnt <= '0;
      halted_q  <= 1'b0;
      mto_q     <= 1'b0;
      sc        <= '0;
    end else begin
      sc    <= sc + CNT_W'(hif.stall_f);
      mto_q <= mto_q | (ms == MWAIT && mstall && wait_cnt == WW'(MEM_TIMEOUT));
      if (ms == MIDLE) begin
        ms       <= mstall ? MWAIT : MIDLE;
        wait_cnt <= mstall ? WW'(1) : '0;
      end else if (!mstall) begin
        ms       <= MIDLE;
        wait_cnt <= '0;
      end else if (wait_cnt != WW'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
      if (hs == RUN && hif.halt_req) begin
        hs        <= DRAIN;
        drain_cnt <= DW'(PIPE_DRAIN);
      end else if (hs == DRAIN && !mstall) begin
        drain_cnt <= drain_cnt - 1'b1;
        if (drain_cnt == DW'(1)) begin
          hs       <= HALTED;
          halted_q <= 1'b1;
        end
      end else if (hs == HALTED && !hif.halt_req) begin
        hs       <= RUN;
        halted_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;
  localparam logic [6:0] IDLE = 7'b0001010;
  localparam logic [6:0] LW   = 7'b1101110;
  localparam logic [6:0] BR   = 7'b0011110;
  localparam logic [6:0] MS   = 7'b1100001;
  localparam logic [6:0] DR   = 7'b1011010;
  localparam logic [6:0] HL   = 7'b1100000;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_sc = '0;
  logic [44:0] sb[$];
  hazard_ctrl_if #(.CNT_W(32)) hif ();
  hazard_ctrl #(.PIPE_DRAIN(3), .MEM_TIMEOUT(255), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .hif(hif));
  always #5 clk = ~clk;
  task automatic clr();
    {hif.rs1_d, hif.rs2_d, hif.rs1_e, hif.rs2_e, hif.rd_e, hif.rd_m, hif.rd_w} = '0;
    hif.result_src_e = 2'b00;
    {hif.pc_src_e, hif.reg_write_m, hif.reg_write_w, hif.mem_req_m, hif.mem_ready, hif.halt_req} = '0;
  endtask
  // {stall_f,stall_d,flush_d,en_e,flush_e,en_m,flush_w}, fwd_a, fwd_b, halted, mem_timeout, stall_cycles
  task automatic step(input string tag, input logic [6:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                      input logic h, input logic mt);
    logic [44:0] e, obs;
    sb.push_back({ctl, fa, fb, h, mt, exp_sc});
    #2;
    e   = sb.pop_front();
    obs = {hif.stall_f, hif.stall_d, hif.flush_d, hif.en_e, hif.flush_e, hif.en_m, hif.flush_w,
           hif.fwd_a_e, hif.fwd_b_e, hif.halted, hif.mem_timeout, hif.stall_cycles};
    n_cmp++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
    if (ctl[6]) exp_sc++;
    @(negedge clk);
  endtask
  initial begin
    clr();
    rst_n = 1'b0;
    @(negedge clk);
    step("reset", IDLE, 2'b00, 2'b00, 0, 0);
    rst_n = 1'b1;
    step("idle", IDLE, 2'b00, 2'b00, 0, 0);
    hif.rd_m = 5; hif.reg_write_m = 1; hif.rd_w = 5; hif.reg_write_w = 1; hif.rs1_e = 5; hif.rs2_e = 5;
    step("fwd_m_over_w", IDLE, 2'b10, 2'b10, 0, 0);
    hif.reg_write_m = 0;
    step("fwd_w", IDLE, 2'b01, 2'b01, 0, 0);
    hif.reg_write_m = 1; hif.rs2_e = 9; hif.rd_w = 9;
    step("fwd_mix", IDLE, 2'b10, 2'b01, 0, 0);
    clr(); hif.reg_write_m = 1; hif.reg_write_w = 1;
    step("fwd_x0", IDLE, 2'b00, 2'b00, 0, 0);
    clr(); hif.rd_m = 4; hif.rd_w = 4; hif.rs1_e = 4; hif.rs2_e = 4;
    step("fwd_nowrite", IDLE, 2'b00, 2'b00, 0, 0);
    clr(); hif.result_src_e = 2'b01; hif.rd_e = 7; hif.rs2_d = 7;
    step("lw_use", LW, 2'b00, 2'b00, 0, 0);
    clr();
    step("lw_after", IDLE, 2'b00, 2'b00, 0, 0);
    hif.result_src_e = 2'b01;
    step("lw_x0", IDLE, 2'b00, 2'b00, 0, 0);
    hif.result_src_e = 2'b00; hif.rd_e = 7; hif.rs1_d = 7;
    step("lw_notload", IDLE, 2'b00, 2'b00, 0, 0);
    hif.result_src_e = 2'b01; hif.pc_src_e = 1;
    step("br_over_lw", BR, 2'b00, 2'b00, 0, 0);
    clr(); hif.pc_src_e = 1; hif.mem_req_m = 1;
    for (int i = 0; i < 3; i++) step("ms_br", MS, 2'b00, 2'b00, 0, 0);
    hif.mem_ready = 1;
    step("ms_br_done", BR, 2'b00, 2'b00, 0, 0);
    clr();
    step("ms_idle", IDLE, 2'b00, 2'b00, 0, 0);
    hif.mem_req_m = 1;
    for (int i = 0; i < 256; i++) step("ms_wait", MS, 2'b00, 2'b00, 0, 0);
    hif.mem_ready = 1;
    step("mto_set", IDLE, 2'b00, 2'b00, 0, 1);
    clr();
    step("mto_sticky", IDLE, 2'b00, 2'b00, 0, 1);
    hif.halt_req = 1;
    step("h_req", IDLE, 2'b00, 2'b00, 0, 1);
    step("h_d1", DR, 2'b00, 2'b00, 0, 1);
    hif.mem_req_m = 1;
    step("h_d2_ms", MS, 2'b00, 2'b00, 0, 1);
    step("h_d3_ms", MS, 2'b00, 2'b00, 0, 1);
    hif.mem_ready = 1;
    step("h_d4", DR, 2'b00, 2'b00, 0, 1);
    clr(); hif.halt_req = 1;
    step("h_d5", DR, 2'b00, 2'b00, 0, 1);
    step("h_halted", HL, 2'b00, 2'b00, 1, 1);
    hif.halt_req = 0;
    step("h_release", HL, 2'b00, 2'b00, 1, 1);
    step("h_resume", IDLE, 2'b00, 2'b00, 0, 1);
    hif.halt_req = 1;
    step("h2_req", IDLE, 2'b00, 2'b00, 0, 1);
    hif.halt_req = 0;
    step("h2_d1", DR, 2'b00, 2'b00, 0, 1);
    hif.pc_src_e = 1;
    step("h2_d2_br", BR, 2'b00, 2'b00, 0, 1);
    hif.pc_src_e = 0;
    step("h2_d3", DR, 2'b00, 2'b00, 0, 1);
    step("h2_halted", HL, 2'b00, 2'b00, 1, 1);
    step("h2_run", IDLE, 2'b00, 2'b00, 0, 1);
    hif.halt_req = 1;
    step("h3_req", IDLE, 2'b00, 2'b00, 0, 1);
    step("h3_d1", DR, 2'b00, 2'b00, 0, 1);
    rst_n = 1'b0; clr(); exp_sc = '0;
    step("rst_mid_drain", IDLE, 2'b00, 2'b00, 0, 0);
    rst_n = 1'b1;
    step("post_rst", IDLE, 2'b00, 2'b00, 0, 0);
    hif.halt_req = 1;
    step("h4_req", IDLE, 2'b00, 2'b00, 0, 0);
    step("h4_d1", DR, 2'b00, 2'b00, 0, 0);
    step("h4_d2", DR, 2'b00, 2'b00, 0, 0);
    step("h4_d3", DR, 2'b00, 2'b00, 0, 0);
    step("h4_halted", HL, 2'b00, 2'b00, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
